// File: rtl/data_mem_responder_if.sv
// Load/store handshake between the CPU datapath and the data memory responder.
// The CPU side (master) drives the request; the memory side (slave) answers
// with registered data, a one-cycle ready pulse, a busy level and an error flag.
interface data_mem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        mem_ready;
  logic        mem_busy;
  logic        mem_err;

  modport master (
    output MemRead, MemWrite, addr, wr_data,
    input  rd_data, mem_ready, mem_busy, mem_err
  );

  modport slave (
    input  MemRead, MemWrite, addr, wr_data,
    output rd_data, mem_ready, mem_busy, mem_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed number of wait states.
// A request seen in IDLE is latched, optionally waits WAIT_STATES cycles,
// then completes in DONE with a one-cycle ready pulse. Reads are registered
// on the edge entering DONE; writes land on the edge leaving DONE so that a
// following load to the same word always sees the new data.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_responder_if.slave   bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // An access is illegal when misaligned, beyond the array, or both a load and a store.
  function automatic logic access_illegal(input logic [31:0] a, input logic rd, input logic wr);
    logic misaligned;
    logic out_of_range;
    logic both_ops;
    misaligned   = (a[1:0] != 2'b00);
    out_of_range = ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS));
    both_ops     = rd & wr;
    return misaligned | out_of_range | both_ops;
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  state_t          state_r;
  state_t          next_state_s;
  logic [3:0]      cnt_r;
  logic [31:0]     addr_r;
  logic [31:0]     wdata_r;
  logic            rd_op_r;
  logic            wr_op_r;
  logic            err_r;

  logic [31:0]     rd_data_r;
  logic            mem_ready_r;
  logic            mem_busy_r;
  logic            mem_err_r;

  logic            req_s;
  logic [31:0]     acc_addr_s;
  logic            acc_rd_s;
  logic            acc_wr_s;
  logic            acc_err_s;
  logic [AW-1:0]   acc_idx_s;

  assign req_s = bus.MemRead | bus.MemWrite;

  // Next-state logic: accept in IDLE, count down in WAIT, single DONE cycle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          next_state_s = (WAIT_STATES > 0) ? ST_WAIT : ST_DONE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Access view: live inputs at acceptance (needed when DONE follows directly), latched values afterwards.
  always_comb begin
    acc_addr_s = addr_r;
    acc_rd_s   = rd_op_r;
    acc_wr_s   = wr_op_r;
    if (state_r == ST_IDLE) begin
      acc_addr_s = bus.addr;
      acc_rd_s   = bus.MemRead;
      acc_wr_s   = bus.MemWrite;
    end else begin
      acc_addr_s = addr_r;
      acc_rd_s   = rd_op_r;
      acc_wr_s   = wr_op_r;
    end
    acc_err_s = access_illegal(acc_addr_s, acc_rd_s, acc_wr_s);
    acc_idx_s = acc_addr_s[AW+1:2];
  end

  // State register and wait-state counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= next_state_s;
      if (state_r == ST_IDLE && next_state_s == ST_WAIT) begin
        cnt_r <= WAIT_LOAD;
      end else if (state_r == ST_WAIT && cnt_r != 4'd0) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Request capture at acceptance; inputs are ignored until the next IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      rd_op_r <= 1'b0;
      wr_op_r <= 1'b0;
      err_r   <= 1'b0;
    end else if (state_r == ST_IDLE && req_s) begin
      addr_r  <= bus.addr;
      wdata_r <= bus.wr_data;
      rd_op_r <= bus.MemRead;
      wr_op_r <= bus.MemWrite;
      err_r   <= acc_err_s;
    end
  end

  // Registered outputs; read data and error are produced on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r   <= 32'd0;
      mem_ready_r <= 1'b0;
      mem_busy_r  <= 1'b0;
      mem_err_r   <= 1'b0;
    end else begin
      mem_ready_r <= (next_state_s == ST_DONE);
      mem_busy_r  <= (next_state_s != ST_IDLE);
      if (next_state_s == ST_DONE) begin
        mem_err_r <= acc_err_s;
        rd_data_r <= (acc_rd_s && !acc_err_s) ? mem[acc_idx_s] : 32'd0;
      end else begin
        mem_err_r <= 1'b0;
        rd_data_r <= 32'd0;
      end
    end
  end

  // Array write on the edge leaving DONE; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (!rst && state_r == ST_DONE && wr_op_r && !err_r) begin
      mem[addr_r[AW+1:2]] <= wdata_r;
    end
  end

  assign bus.rd_data   = rd_data_r;
  assign bus.mem_ready = mem_ready_r;
  assign bus.mem_busy  = mem_busy_r;
  assign bus.mem_err   = mem_err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder with two wait states (dut_a) and one with
// none (dut_b). A select bit routes the shared request driver to one of them.
module tb_data_mem_responder;

  logic clk;
  logic rst;

  data_mem_responder_if ifa ();
  data_mem_responder_if ifb ();

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  int checks;
  int errors;

  logic        sel;
  logic        mr;
  logic        mw;
  logic [31:0] a_v;
  logic [31:0] wd_v;

  assign ifa.MemRead  = mr & ~sel;
  assign ifa.MemWrite = mw & ~sel;
  assign ifa.addr     = a_v;
  assign ifa.wr_data  = wd_v;
  assign ifb.MemRead  = mr & sel;
  assign ifb.MemWrite = mw & sel;
  assign ifb.addr     = a_v;
  assign ifb.wr_data  = wd_v;

  logic        rdy_m;
  logic        busy_m;
  logic        err_m;
  logic [31:0] rd_m;
  assign rdy_m  = sel ? ifb.mem_ready : ifa.mem_ready;
  assign busy_m = sel ? ifb.mem_busy  : ifa.mem_busy;
  assign err_m  = sel ? ifb.mem_err   : ifa.mem_err;
  assign rd_m   = sel ? ifb.rd_data   : ifa.rd_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issues one request, counts edges until ready; optionally changes addr/data during WAIT.
  task automatic do_access(input logic s, input logic rd, input logic wr,
                           input logic [31:0] ad, input logic [31:0] wd,
                           input logic scramble,
                           output int lat, output logic [31:0] rdat,
                           output logic err, output logic busy_at_rdy);
    logic got;
    got = 1'b0;
    lat = 0;
    rdat = 32'd0;
    err = 1'b0;
    busy_at_rdy = 1'b0;
    sel = s; mr = rd; mw = wr; a_v = ad; wd_v = wd;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (rdy_m) begin
        got = 1'b1;
        rdat = rd_m;
        err = err_m;
        busy_at_rdy = busy_m;
      end else if (scramble && lat == 1) begin
        a_v = ad ^ 32'h4;
        wd_v = ~wd;
      end
    end
    mr = 1'b0;
    mw = 1'b0;
    checks++;
    if (got !== 1'b1) begin
      errors++;
      $display("FAIL timeout addr=%h: no mem_ready within 40 cycles", ad);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      idle(1);
      checks++;
      if ({ifa.mem_ready, ifa.mem_busy, ifa.mem_err, ifa.rd_data} !== 35'd0) begin
        errors++;
        $display("FAIL reset_idle_a cycle %0d: got r/b/e=%b%b%b rd=%h, want all 0",
                 i, ifa.mem_ready, ifa.mem_busy, ifa.mem_err, ifa.rd_data);
      end
      checks++;
      if ({ifb.mem_ready, ifb.mem_busy, ifb.mem_err, ifb.rd_data} !== 35'd0) begin
        errors++;
        $display("FAIL reset_idle_b cycle %0d: got r/b/e=%b%b%b rd=%h, want all 0",
                 i, ifb.mem_ready, ifb.mem_busy, ifb.mem_err, ifb.rd_data);
      end
    end
  endtask

  task automatic test_ws2_write_read();
    int lat; logic [31:0] d; logic e; logic b;
    do_access(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, lat, d, e, b);
    checks++;
    if (lat !== 3 || e !== 1'b0 || b !== 1'b1) begin
      errors++;
      $display("FAIL ws2_write: lat=%0d err=%b busy=%b, want lat=3 err=0 busy=1", lat, e, b);
    end
    idle(1);
    checks++;
    if (ifa.mem_busy !== 1'b0 || ifa.mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL ws2_after_done: busy=%b ready=%b, want 0 0", ifa.mem_busy, ifa.mem_ready);
    end
    do_access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, d, e, b);
    checks++;
    if (lat !== 3 || d !== 32'hDEADBEEF || e !== 1'b0) begin
      errors++;
      $display("FAIL ws2_read: lat=%0d data=%h err=%b, want lat=3 data=deadbeef err=0", lat, d, e);
    end
    idle(1);
  endtask

  task automatic test_ws0_back_to_back();
    int lat; logic [31:0] d; logic e; logic b;
    for (int i = 0; i < 3; i++) begin
      do_access(1'b1, 1'b0, 1'b1, 32'(i * 4), 32'(i + 1), 1'b0, lat, d, e, b);
      checks++;
      if (lat !== ((i == 0) ? 1 : 2) || e !== 1'b0) begin
        errors++;
        $display("FAIL ws0_write%0d: lat=%0d err=%b, want lat=%0d err=0", i, lat, e, (i == 0) ? 1 : 2);
      end
    end
    for (int i = 0; i < 3; i++) begin
      do_access(1'b1, 1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b0, lat, d, e, b);
      checks++;
      if (lat !== 2 || d !== 32'(i + 1) || e !== 1'b0) begin
        errors++;
        $display("FAIL ws0_read%0d: lat=%0d data=%h err=%b, want lat=2 data=%h err=0", i, lat, d, e, 32'(i + 1));
      end
    end
    idle(1);
    sel = 1'b0;
  endtask

  task automatic test_illegal();
    int lat; logic [31:0] d; logic e; logic b;
    do_access(1'b0, 1'b1, 1'b0, 32'h2, 32'h0, 1'b0, lat, d, e, b);
    checks++;
    if (lat !== 3 || e !== 1'b1 || d !== 32'd0) begin
      errors++;
      $display("FAIL illegal_misaligned: lat=%0d err=%b data=%h, want lat=3 err=1 data=0", lat, e, d);
    end
    idle(1);
    do_access(1'b0, 1'b0, 1'b1, 32'h400, 32'hFFFFFFFF, 1'b0, lat, d, e, b);
    checks++;
    if (lat !== 3 || e !== 1'b1 || d !== 32'd0) begin
      errors++;
      $display("FAIL illegal_range: lat=%0d err=%b data=%h, want lat=3 err=1 data=0", lat, e, d);
    end
    idle(1);
    do_access(1'b0, 1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, 1'b0, lat, d, e, b);
    checks++;
    if (lat !== 3 || e !== 1'b1 || d !== 32'd0) begin
      errors++;
      $display("FAIL illegal_both: lat=%0d err=%b data=%h, want lat=3 err=1 data=0", lat, e, d);
    end
    idle(1);
    do_access(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, lat, d, e, b);
    checks++;
    if (d !== 32'h11112222 || e !== 1'b0) begin
      errors++;
      $display("FAIL illegal_word0_kept: data=%h err=%b, want 11112222 err=0", d, e);
    end
    idle(1);
    do_access(1'b0, 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0, lat, d, e, b);
    checks++;
    if (d !== 32'hFEEDFACE || e !== 1'b0) begin
      errors++;
      $display("FAIL last_word_read: data=%h err=%b, want feedface err=0", d, e);
    end
    idle(1);
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] d; logic e; logic b; int seen;
    sel = 1'b0; mr = 1'b0; mw = 1'b1; a_v = 32'h20; wd_v = 32'hAAAA5555;
    idle(1);
    checks++;
    if (ifa.mem_busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_accept: busy=%b, want 1", ifa.mem_busy);
    end
    rst = 1'b1;
    mw = 1'b0;
    idle(1);
    rst = 1'b0;
    checks++;
    if (ifa.mem_busy !== 1'b0 || ifa.mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: busy=%b ready=%b, want 0 0", ifa.mem_busy, ifa.mem_ready);
    end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      if (ifa.mem_ready === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_ready: saw %0d ready pulses, want 0", seen);
    end
    do_access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, lat, d, e, b);
    checks++;
    if (lat !== 3 || d !== 32'h12345678) begin
      errors++;
      $display("FAIL abort_readback: lat=%0d data=%h, want lat=3 data=12345678", lat, d);
    end
    idle(1);
  endtask

  task automatic test_latched_inputs();
    int lat; logic [31:0] d; logic e; logic b;
    do_access(1'b0, 1'b0, 1'b1, 32'h30, 32'h00000055, 1'b1, lat, d, e, b);
    idle(1);
    do_access(1'b0, 1'b1, 1'b0, 32'h34, 32'h0, 1'b0, lat, d, e, b);
    checks++;
    if (d !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL latched_write_other_word: data=%h, want cafef00d", d);
    end
    idle(1);
    do_access(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b1, lat, d, e, b);
    checks++;
    if (d !== 32'h00000055 || lat !== 3) begin
      errors++;
      $display("FAIL latched_read: lat=%0d data=%h, want lat=3 data=00000055", lat, d);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] d; logic e; logic b;
    do_access(1'b0, 1'b0, 1'b1, 32'h40, 32'h5A5A5A5A, 1'b0, lat, d, e, b);
    do_access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, lat, d, e, b);
    checks++;
    if (lat !== 4 || d !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL store_then_load: lat=%0d data=%h, want lat=4 data=5a5a5a5a", lat, d);
    end
    idle(1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sel = 1'b0; mr = 1'b0; mw = 1'b0; a_v = 32'd0; wd_v = 32'd0;
    rst = 1'b1;
    dut_a.mem[0]   = 32'h11112222;
    dut_a.mem[8]   = 32'h12345678;
    dut_a.mem[13]  = 32'hCAFEF00D;
    dut_a.mem[255] = 32'hFEEDFACE;
    idle(3);
    rst = 1'b0;
    test_reset();
    test_ws2_write_read();
    test_ws0_back_to_back();
    test_illegal();
    test_reset_abort();
    test_latched_inputs();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
